// File: rtl/divider_pkg.sv
// divider_pkg
//   Shared definitions for the divider block: default operand/result widths
//   and the sequencing state encoding.
package divider_pkg;

  localparam int DIVIDEND_W = 26;
  localparam int DIVISOR_W  = 26;
  localparam int RES_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_step.sv
// divider_step
//   One combinational restoring-division step: shift the partial remainder
//   left, bring in the next dividend bit, and subtract the divisor when it fits.
// Ports
//   rem_in   partial remainder before this step (WIDTH+1 bits)
//   bit_in   next dividend bit, MSB first
//   divisor  unsigned denominator
//   rem_out  partial remainder after this step
//   q_bit    quotient bit produced by this step
module divider_step #(
  parameter int WIDTH = divider_pkg::DIVISOR_W
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisor_ext;

  // The remainder is always below the divisor, so its top bit is shifted out
  // without loss; the extra bit holds the carry of the shift.
  assign shifted     = (rem_in << 1) | (WIDTH+1)'(bit_in);
  assign divisor_ext = {1'b0, divisor};

  always_comb begin
    q_bit   = 1'b0;
    rem_out = shifted;
    if (shifted >= divisor_ext) begin
      q_bit   = 1'b1;
      rem_out = shifted - divisor_ext;
    end
  end

endmodule

// File: rtl/divider.sv
// divider
//   Iterative unsigned divider with a saturated, registered quotient.
//   One shift-subtract step per cycle, DIVIDEND_W cycles per division.
// Ports
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   start       single-cycle request; accepted in IDLE or DONE, ignored in CALC
//   dividend    numerator, sampled on the accepted start
//   divisor     denominator, sampled on the accepted start
//   dividerres  saturated quotient, held from completion until the next start
//   Busy        division iterating
//   Ready       dividerres holds a completed result
//   div_zero    last result came from a zero divisor
//   ovf         last true quotient exceeded the result range
module divider
  import divider_pkg::state_t, divider_pkg::IDLE, divider_pkg::CALC, divider_pkg::DONE;
#(
  parameter int DIVIDEND_W = divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = divider_pkg::DIVISOR_W,
  parameter int RES_W      = divider_pkg::RES_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [RES_W-1:0]      dividerres,
  output logic                  Busy,
  output logic                  Ready,
  output logic                  div_zero,
  output logic                  ovf
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam int QW    = (DIVIDEND_W > RES_W) ? DIVIDEND_W : RES_W;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [RES_W-1:0]      res_q, res_d;
  logic                  dz_q, dz_d;
  logic                  ovf_q, ovf_d;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] quo_next;
  logic [QW-1:0]         quo_ext;
  logic [QW-1:0]         res_max;

  divider_step #(
    .WIDTH (DIVISOR_W)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[DIVIDEND_W-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // The quotient register starts as the dividend; each step shifts one
  // dividend bit out of the top and one quotient bit in at the bottom.
  assign quo_next = (quo_q << 1) | DIVIDEND_W'(step_q);
  assign quo_ext  = QW'(quo_next);
  assign res_max  = QW'({RES_W{1'b1}});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          quo_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = CNT_W'(DIVIDEND_W - 1);
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        quo_d = quo_next;
        rem_d = step_rem;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (dvs_q == '0) begin
            res_d = '1;
            dz_d  = 1'b1;
          end else if (quo_ext > res_max) begin
            res_d = '1;
            ovf_d = 1'b1;
          end else begin
            res_d = quo_ext[RES_W-1:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dividerres = res_q;
  assign Busy       = (state_q == CALC);
  assign Ready      = (state_q == DONE);
  assign div_zero   = dz_q;
  assign ovf        = ovf_q;

endmodule
